// File: rtl/modulo_controle_ataque_if.sv
// Bus between the attack controller and its surroundings: debounced button,
// attack coordinate, ship map in; attack map, result and game state out.
interface modulo_controle_ataque_if;
  logic        button_confirmation;
  logic [5:0]  coord_at;
  logic [34:0] m_po;
  logic [34:0] m_at;
  logic [1:0]  status;
  logic [3:0]  acertos;
  logic        fim_jogo;
  logic        atk_valid;

  modport master (
    output button_confirmation, coord_at, m_po,
    input  m_at, status, acertos, fim_jogo, atk_valid
  );

  modport slave (
    input  button_confirmation, coord_at, m_po,
    output m_at, status, acertos, fim_jogo, atk_valid
  );
endinterface

// File: rtl/modulo_controle_ataque.sv
// Battleship attack controller: synchronizes and debounces the confirm button,
// evaluates one attack per accepted press and tracks hits until game over.
module modulo_controle_ataque #(
  parameter int DEB_CYCLES = 50000,
  parameter int HIT_TOTAL  = 9
) (
  input  logic                       clk,
  input  logic                       clr,
  modulo_controle_ataque_if.slave    bus
);

  localparam int            CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [3:0]    HIT_GOAL = 4'(HIT_TOTAL);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DEBOUNCE = 3'd1;
  localparam logic [2:0] S_EVAL     = 3'd2;
  localparam logic [2:0] S_WAIT_REL = 3'd3;
  localparam logic [2:0] S_END      = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          btn_meta;
  logic          btn_s;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Cell (r,c) lives at bit 5c+4-r; out-of-range coordinates select no cell.
  logic [2:0]  row;
  logic [2:0]  col;
  logic        in_range;
  logic [5:0]  cell_idx;
  logic [34:0] cell_mask;
  logic        repeated;
  logic        ship_hit;

  assign row       = bus.coord_at[5:3];
  assign col       = bus.coord_at[2:0];
  assign in_range  = (row <= 3'd4) && (col <= 3'd6);
  assign cell_idx  = ({3'b000, col} * 6'd5) + 6'd4 - {3'b000, row};
  assign cell_mask = in_range ? (35'd1 << cell_idx) : 35'd0;
  assign repeated  = |(bus.m_at & cell_mask);
  assign ship_hit  = |(bus.m_po & cell_mask);

  logic [1:0]  eval_status;
  logic [34:0] eval_mat;
  logic [3:0]  eval_hits;
  logic        game_done;

  always_comb begin
    eval_status = 2'b11;
    eval_mat    = bus.m_at;
    eval_hits   = bus.acertos;
    if (in_range && !repeated) begin
      eval_mat = bus.m_at | cell_mask;
      if (ship_hit) begin
        eval_status = 2'b10;
        eval_hits   = sat_inc(bus.acertos);
      end else begin
        eval_status = 2'b01;
      end
    end
  end

  assign game_done = (eval_hits == HIT_GOAL);

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      btn_meta <= 1'b1;
      btn_s    <= 1'b1;
    end else begin
      btn_meta <= bus.button_confirmation;
      btn_s    <= btn_meta;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bus.m_at      <= '0;
      bus.status    <= 2'b00;
      bus.acertos   <= 4'd0;
      bus.fim_jogo  <= 1'b0;
      bus.atk_valid <= 1'b0;
    end else begin
      bus.atk_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!btn_s) begin
            state <= S_DEBOUNCE;
            cnt   <= '0;
          end
        end
        S_DEBOUNCE: begin
          if (btn_s) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= S_EVAL;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_EVAL: begin
          bus.m_at      <= eval_mat;
          bus.status    <= eval_status;
          bus.acertos   <= eval_hits;
          bus.atk_valid <= 1'b1;
          cnt           <= '0;
          if (game_done) begin
            bus.fim_jogo <= 1'b1;
            state        <= S_END;
          end else begin
            state <= S_WAIT_REL;
          end
        end
        // A held button keeps clearing the counter, so it cannot re-arm.
        S_WAIT_REL: begin
          if (!btn_s) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_END: begin
          state <= S_END;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modulo_controle_ataque.sv
// Self-checking bench for modulo_controle_ataque with DEB_CYCLES=4, HIT_TOTAL=2:
// directed vector table, multi-cycle corner sequences and a randomized model run.
module tb_modulo_controle_ataque;

  localparam int DEB = 4;
  localparam int HITS_END = 2;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  modulo_controle_ataque_if bus();

  modulo_controle_ataque #(.DEB_CYCLES(DEB), .HIT_TOTAL(HITS_END)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  int   pulses;
  logic fim_at_pulse;
  int   k;
  int   lat;

  typedef struct {
    logic [5:0]  coord;
    int          pulses;
    logic [1:0]  status;
    logic [34:0] mat;
    logic [3:0]  hits;
    logic        fim;
  } vec_t;

  vec_t tbl[7];

  logic [34:0] ref_mat;
  logic [3:0]  ref_hits;
  logic [1:0]  ref_status;
  logic        ref_over;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    k++;
    if (bus.atk_valid === 1'b1) begin
      pulses++;
      fim_at_pulse = bus.fim_jogo;
      if (lat == 0) lat = k;
    end
  endtask

  task automatic press(input logic [5:0] c, input int hold, input int rel);
    bus.coord_at = c;
    pulses = 0; k = 0; lat = 0; fim_at_pulse = 1'b0;
    bus.button_confirmation = 1'b0;
    repeat (hold) tick();
    bus.button_confirmation = 1'b1;
    repeat (rel) tick();
  endtask

  task automatic do_reset();
    bus.button_confirmation = 1'b1;
    clr = 1'b0;
    repeat (2) tick();
    clr = 1'b1;
    repeat (2) tick();
  endtask

  task automatic check_outputs(input string tag, input logic [34:0] mat, input logic [1:0] st,
                               input logic [3:0] hits, input logic fim);
    check({tag, ".m_at"}, 64'(bus.m_at), 64'(mat));
    check({tag, ".status"}, 64'(bus.status), 64'(st));
    check({tag, ".acertos"}, 64'(bus.acertos), 64'(hits));
    check({tag, ".fim_jogo"}, 64'(bus.fim_jogo), 64'(fim));
  endtask

  // Reference: board rules applied to one accepted press.
  task automatic model_attack(input logic [5:0] c);
    int r, col, idx;
    r   = int'(c[5:3]);
    col = int'(c[2:0]);
    if (r > 4 || col > 6) begin
      ref_status = 2'b11;
    end else begin
      idx = 5 * col + 4 - r;
      if (ref_mat[idx]) begin
        ref_status = 2'b11;
      end else begin
        ref_mat[idx] = 1'b1;
        if (bus.m_po[idx]) begin
          ref_status = 2'b10;
          if (ref_hits != 4'd15) ref_hits = ref_hits + 4'd1;
        end else begin
          ref_status = 2'b01;
        end
      end
    end
    if (int'(ref_hits) == HITS_END) ref_over = 1'b1;
  endtask

  initial begin
    logic [34:0] m;
    logic [5:0]  c, last_c;
    logic [31:0] r32;
    bit          glitch;
    int          exp_p;

    tbl[0] = '{6'b000_110, 1, 2'b10, 35'h4_0000_0000, 4'd1, 1'b0};
    tbl[1] = '{6'b000_000, 1, 2'b01, 35'h4_0000_0010, 4'd1, 1'b0};
    tbl[2] = '{6'b000_110, 1, 2'b11, 35'h4_0000_0010, 4'd1, 1'b0};
    tbl[3] = '{6'b101_000, 1, 2'b11, 35'h4_0000_0010, 4'd1, 1'b0};
    tbl[4] = '{6'b000_111, 1, 2'b11, 35'h4_0000_0010, 4'd1, 1'b0};
    tbl[5] = '{6'b001_001, 1, 2'b10, 35'h4_0000_0110, 4'd2, 1'b1};
    tbl[6] = '{6'b000_001, 0, 2'b10, 35'h4_0000_0110, 4'd2, 1'b1};

    pulses = 0; k = 0; lat = 0; fim_at_pulse = 1'b0;
    bus.button_confirmation = 1'b1;
    bus.coord_at = 6'd0;
    bus.m_po = 35'h4_0000_0100;
    repeat (2) tick();
    check_outputs("reset", 35'd0, 2'b00, 4'd0, 1'b0);
    check("reset.atk_valid", 64'(bus.atk_valid), 64'd0);
    clr = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 7; i++) begin
      press(tbl[i].coord, 10, 12);
      check($sformatf("vec%0d.pulses", i), 64'(pulses), 64'(tbl[i].pulses));
      check_outputs($sformatf("vec%0d", i), tbl[i].mat, tbl[i].status, tbl[i].hits, tbl[i].fim);
      if (tbl[i].pulses == 1)
        check($sformatf("vec%0d.fim_with_pulse", i), 64'(fim_at_pulse), 64'(tbl[i].fim));
      if (i == 0)
        check("vec0.latency", 64'(lat), 64'(DEB + 4));
    end

    // Held button with coordinate changing after the evaluation.
    do_reset();
    pulses = 0; k = 0; lat = 0;
    bus.coord_at = 6'b000_110;
    bus.button_confirmation = 1'b0;
    repeat (20) tick();
    bus.coord_at = 6'b001_001;
    repeat (20) tick();
    bus.button_confirmation = 1'b1;
    repeat (12) tick();
    check("held.pulses", 64'(pulses), 64'd1);
    check_outputs("held", 35'h4_0000_0000, 2'b10, 4'd1, 1'b0);

    // Bouncing contact never reaches the debounce threshold.
    pulses = 0;
    bus.button_confirmation = 1'b0; repeat (3) tick();
    bus.button_confirmation = 1'b1; repeat (1) tick();
    bus.button_confirmation = 1'b0; repeat (3) tick();
    bus.button_confirmation = 1'b1; repeat (12) tick();
    check("bounce.pulses", 64'(pulses), 64'd0);
    check_outputs("bounce", 35'h4_0000_0000, 2'b10, 4'd1, 1'b0);
    press(6'b000_000, 10, 12);
    check("after_bounce.latency", 64'(lat), 64'(DEB + 4));
    check("after_bounce.status", 64'(bus.status), 64'(2'b01));

    // Reset in the middle of a debounce.
    pulses = 0;
    bus.coord_at = 6'b000_110;
    bus.button_confirmation = 1'b0;
    repeat (4) tick();
    clr = 1'b0;
    #1;
    check_outputs("clr_mid", 35'd0, 2'b00, 4'd0, 1'b0);
    check("clr_mid.atk_valid", 64'(bus.atk_valid), 64'd0);
    bus.button_confirmation = 1'b1;
    repeat (2) tick();
    clr = 1'b1;
    pulses = 0;
    repeat (20) tick();
    check("clr_mid.no_attack", 64'(pulses), 64'd0);
    check("clr_mid.m_at_held", 64'(bus.m_at), 64'd0);
    press(6'b000_110, 10, 12);
    check("clr_mid.new_press", 64'(bus.status), 64'(2'b10));

    // Randomized games against the reference model.
    for (int g = 0; g < 6; g++) begin
      r32 = $urandom;
      m = {3'($urandom_range(7, 0)), r32};
      bus.m_po = m;
      do_reset();
      ref_mat = '0; ref_hits = 4'd0; ref_status = 2'b00; ref_over = 1'b0;
      last_c = 6'd0;
      for (int p = 0; p < 8; p++) begin
        if ($urandom_range(3, 0) == 0)
          c = last_c;
        else if ($urandom_range(1, 0) == 1)
          c = {3'($urandom_range(4, 0)), 3'($urandom_range(6, 0))};
        else
          c = 6'($urandom);
        glitch = ($urandom_range(3, 0) == 0);
        exp_p = (glitch || ref_over) ? 0 : 1;
        if (exp_p == 1) begin
          model_attack(c);
          last_c = c;
        end
        press(c, glitch ? $urandom_range(2, 1) : $urandom_range(20, 10), $urandom_range(16, 12));
        check($sformatf("rnd%0d_%0d.pulses", g, p), 64'(pulses), 64'(exp_p));
        check_outputs($sformatf("rnd%0d_%0d", g, p), ref_mat, ref_status, ref_hits, ref_over);
        if (exp_p == 1)
          check($sformatf("rnd%0d_%0d.fim_with_pulse", g, p), 64'(fim_at_pulse), 64'(ref_over));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
